// File: rtl/local_ni.sv
// Local NI: credit-based endpoint on the router local port (TX inject, RX receive + credit return).
// Latency: core push -> net_tx_valid_o two edges; router flit -> core_rx_valid_o one edge.
// Backpressure: TX stalls at zero credits / core_tx_ready_o low when full; RX drops and flags err_o when full.

// Generic synchronous FIFO with show-ahead head; a push into a full FIFO is taken only alongside a pop.
module local_ni_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         pop_ok;
    logic         push_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    // Head reads as zero while empty so stale entries never leak out.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Next storage and pointer values for this cycle's push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Storage and pointer registers; reset discards all contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

module local_ni #(
    parameter int FLIT_W     = 32,
    parameter int TX_CREDITS = 4,
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FLIT_W-1:0]                 core_tx_data_i,
    input  logic                              core_tx_valid_i,
    output logic                              core_tx_ready_o,
    output logic [FLIT_W-1:0]                 net_tx_data_o,
    output logic                              net_tx_valid_o,
    input  logic                              net_tx_credit_i,
    input  logic [FLIT_W-1:0]                 net_rx_data_i,
    input  logic                              net_rx_valid_i,
    output logic                              net_rx_credit_o,
    output logic [FLIT_W-1:0]                 core_rx_data_o,
    output logic                              core_rx_valid_o,
    input  logic                              core_rx_ready_i,
    output logic [$clog2(TX_CREDITS+1)-1:0]   tx_credits_o,
    output logic                              err_o
);
    localparam int CW = $clog2(TX_CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(TX_CREDITS);

    logic [FLIT_W-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_push;
    logic              send;

    logic              rx_full;
    logic              rx_empty;
    logic              rx_pop;
    logic              rx_drop;

    logic [CW-1:0]     credits_q, credits_d;
    logic              cred_ovf;
    logic [FLIT_W-1:0] tx_data_q, tx_data_d;
    logic              tx_vld_q, tx_vld_d;
    logic              rx_credit_q, rx_credit_d;
    logic              err_q, err_d;

    // Ready is taken from the pre-pop full flag, so a full FIFO refuses a push even while it sends.
    assign core_tx_ready_o = !tx_full;
    assign tx_push         = core_tx_valid_i && !tx_full;
    assign send            = !tx_empty && (credits_q != '0);

    assign core_rx_valid_o = !rx_empty;
    assign rx_pop          = !rx_empty && core_rx_ready_i;
    assign rx_drop         = net_rx_valid_i && rx_full && !rx_pop;

    local_ni_fifo #(.W(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .pop_i   (send),
        .data_i  (core_tx_data_i),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    local_ni_fifo #(.W(FLIT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (net_rx_valid_i),
        .pop_i   (rx_pop),
        .data_i  (net_rx_data_i),
        .data_o  (core_rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // Credit bookkeeping: a send spends one, a return refunds one, both together cancel out.
    always_comb begin
        credits_d = credits_q;
        cred_ovf  = 1'b0;
        if (send && !net_tx_credit_i) begin
            credits_d = credits_q - 1'b1;
        end else if (!send && net_tx_credit_i) begin
            if (credits_q == CRED_MAX) begin
                cred_ovf = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end
    end

    // Output strobes, held TX data and the sticky error flag.
    always_comb begin
        tx_vld_d    = send;
        tx_data_d   = send ? tx_head : tx_data_q;
        rx_credit_d = rx_pop;
        err_d       = err_q || cred_ovf || rx_drop;
    end

    // Registered state; reset restores full credits and clears all strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q   <= CRED_MAX;
            tx_data_q   <= '0;
            tx_vld_q    <= 1'b0;
            rx_credit_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            credits_q   <= credits_d;
            tx_data_q   <= tx_data_d;
            tx_vld_q    <= tx_vld_d;
            rx_credit_q <= rx_credit_d;
            err_q       <= err_d;
        end
    end

    assign tx_credits_o    = credits_q;
    assign net_tx_data_o   = tx_data_q;
    assign net_tx_valid_o  = tx_vld_q;
    assign net_rx_credit_o = rx_credit_q;
    assign err_o           = err_q;
endmodule

// File: tb/tb_local_ni.sv
// Bench for local_ni: queue-based reference model updated on each clock edge,
// expected flits scoreboarded and checked by a negedge monitor,
// directed scenarios followed by a randomized phase and a drain.
module tb_local_ni;
    localparam int W   = 32;
    localparam int TXC = 4;
    localparam int TXD = 4;
    localparam int RXD = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] core_tx_data_i = '0;
    logic         core_tx_valid_i = 1'b0;
    logic         core_tx_ready_o;
    logic [W-1:0] net_tx_data_o;
    logic         net_tx_valid_o;
    logic         net_tx_credit_i = 1'b0;
    logic [W-1:0] net_rx_data_i = '0;
    logic         net_rx_valid_i = 1'b0;
    logic         net_rx_credit_o;
    logic [W-1:0] core_rx_data_o;
    logic         core_rx_valid_o;
    logic         core_rx_ready_i = 1'b0;
    logic [2:0]   tx_credits_o;
    logic         err_o;

    local_ni #(.FLIT_W(W), .TX_CREDITS(TXC), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk             (clk),
        .rst             (rst),
        .core_tx_data_i  (core_tx_data_i),
        .core_tx_valid_i (core_tx_valid_i),
        .core_tx_ready_o (core_tx_ready_o),
        .net_tx_data_o   (net_tx_data_o),
        .net_tx_valid_o  (net_tx_valid_o),
        .net_tx_credit_i (net_tx_credit_i),
        .net_rx_data_i   (net_rx_data_i),
        .net_rx_valid_i  (net_rx_valid_i),
        .net_rx_credit_o (net_rx_credit_o),
        .core_rx_data_o  (core_rx_data_o),
        .core_rx_valid_o (core_rx_valid_o),
        .core_rx_ready_i (core_rx_ready_i),
        .tx_credits_o    (tx_credits_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    int rx_seen = 0;

    // Reference model state
    logic [W-1:0] tx_q[$];     // flits accepted from core, not yet sent
    logic [W-1:0] exp_tx[$];   // flits expected on net_tx
    logic [W-1:0] exp_rx[$];   // flits expected at core_rx, in order
    int           cred_m = TXC;
    int           rx_cnt_m = 0;
    bit           err_m = 0;
    bit           tx_vld_m = 0;
    bit           rxc_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one step per clock edge using this cycle's inputs.
    always @(posedge clk or posedge rst) begin
        bit send, push, pop;
        if (rst) begin
            tx_q.delete();
            exp_tx.delete();
            exp_rx.delete();
            cred_m   = TXC;
            rx_cnt_m = 0;
            err_m    = 0;
            tx_vld_m = 0;
            rxc_m    = 0;
        end else begin
            send = (tx_q.size() > 0) && (cred_m > 0);
            push = core_tx_valid_i && (tx_q.size() < TXD);
            if (send) exp_tx.push_back(tx_q.pop_front());
            if (send && !net_tx_credit_i) cred_m--;
            else if (!send && net_tx_credit_i) begin
                if (cred_m == TXC) err_m = 1;
                else cred_m++;
            end
            if (push) tx_q.push_back(core_tx_data_i);
            tx_vld_m = send;
            pop   = core_rx_ready_i && (rx_cnt_m > 0);
            rxc_m = pop;
            if (net_rx_valid_i) begin
                if (rx_cnt_m < RXD || pop) begin
                    exp_rx.push_back(net_rx_data_i);
                    rx_cnt_m++;
                end else begin
                    err_m = 1;
                end
            end
            if (pop) rx_cnt_m--;
        end
    end

    // Monitor: compares DUT outputs to the model mid-cycle and pops scoreboards on transfers.
    always @(negedge clk) begin
        if (!rst) begin
            check("tx_credits", 32'(tx_credits_o), 32'(cred_m));
            check("err", 32'(err_o), 32'(err_m));
            check("net_tx_valid", 32'(net_tx_valid_o), 32'(tx_vld_m));
            check("net_rx_credit", 32'(net_rx_credit_o), 32'(rxc_m));
            check("core_rx_valid", 32'(core_rx_valid_o), 32'(rx_cnt_m > 0));
            check("core_tx_ready", 32'(core_tx_ready_o), 32'(tx_q.size() < TXD));
            if (net_tx_valid_o) begin
                tx_seen++;
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL net_tx_data: unexpected flit %0h, none expected", net_tx_data_o);
                end else begin
                    check("net_tx_data", net_tx_data_o, exp_tx.pop_front());
                end
            end
            if (core_rx_valid_o && core_rx_ready_i) begin
                rx_seen++;
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL core_rx_data: unexpected flit %0h, none expected", core_rx_data_o);
                end else begin
                    check("core_rx_data", core_rx_data_o, exp_rx.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        core_tx_valid_i = 1'b0;
        net_tx_credit_i = 1'b0;
        net_rx_valid_i  = 1'b0;
        core_rx_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc(2);
        #2 rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        int base;
        #2;
        // Reset then idle
        do_reset();
        check("rst_credits", 32'(tx_credits_o), 32'd4);
        check("rst_tx_ready", 32'(core_tx_ready_o), 32'd1);
        check("rst_tx_valid", 32'(net_tx_valid_o), 32'd0);
        check("rst_rx_credit", 32'(net_rx_credit_o), 32'd0);
        check("rst_rx_valid", 32'(core_rx_valid_o), 32'd0);
        check("rst_rx_data", core_rx_data_o, 32'd0);
        check("rst_tx_data", net_tx_data_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        cyc(3);

        // Credit exhaustion: six flits, four credits
        base = tx_seen;
        for (int i = 0; i < 6; i++) begin
            core_tx_valid_i = 1'b1;
            core_tx_data_i  = 32'hA0 + 32'(i);
            cyc();
        end
        core_tx_valid_i = 1'b0;
        cyc(4);
        check("exhaust_pulses", 32'(tx_seen - base), 32'd4);
        check("exhaust_credits", 32'(tx_credits_o), 32'd0);
        net_tx_credit_i = 1'b1;
        cyc();
        net_tx_credit_i = 1'b0;
        cyc();
        check("release_a4", net_tx_data_o, 32'hA4);
        cyc(2);
        // one more credit flushes 0xA5, then two credits bring the count to 2
        net_tx_credit_i = 1'b1;
        cyc(3);
        net_tx_credit_i = 1'b0;
        cyc();
        check("credits_two", 32'(tx_credits_o), 32'd2);
        // Simultaneous send and credit return at credits = 2
        core_tx_valid_i = 1'b1;
        core_tx_data_i  = 32'hC0;
        cyc();
        core_tx_valid_i = 1'b0;
        net_tx_credit_i = 1'b1;
        cyc();
        net_tx_credit_i = 1'b0;
        check("send_and_return", 32'(tx_credits_o), 32'd2);
        check("send_and_return_vld", 32'(net_tx_valid_o), 32'd1);
        net_tx_credit_i = 1'b1;
        cyc(2);
        check("credits_full", 32'(tx_credits_o), 32'd4);
        check("no_err_yet", 32'(err_o), 32'd0);
        cyc();
        net_tx_credit_i = 1'b0;
        cyc();
        check("ovf_credits", 32'(tx_credits_o), 32'd4);
        check("ovf_err", 32'(err_o), 32'd1);

        // RX fill and drain with overflow
        do_reset();
        for (int i = 0; i < 5; i++) begin
            net_rx_valid_i = 1'b1;
            net_rx_data_i  = 32'hB0 + 32'(i);
            cyc();
        end
        net_rx_valid_i = 1'b0;
        check("rx_drop_err", 32'(err_o), 32'd1);
        base = rx_seen;
        core_rx_ready_i = 1'b1;
        cyc(4);
        core_rx_ready_i = 1'b0;
        cyc(2);
        check("rx_drained", 32'(rx_seen - base), 32'd4);

        // RX full with a same-cycle pop and push
        do_reset();
        for (int i = 0; i < 4; i++) begin
            net_rx_valid_i = 1'b1;
            net_rx_data_i  = 32'hD0 + 32'(i);
            cyc();
        end
        core_rx_ready_i = 1'b1;
        net_rx_data_i   = 32'hD4;
        cyc();
        net_rx_valid_i = 1'b0;
        check("full_pop_push_err", 32'(err_o), 32'd0);
        base = rx_seen;
        cyc(5);
        core_rx_ready_i = 1'b0;
        check("full_pop_push_drained", 32'(rx_seen - base), 32'd4);

        // Reset mid-stream: three flits queued in TX, two in RX
        do_reset();
        for (int i = 0; i < 7; i++) begin
            core_tx_valid_i = 1'b1;
            core_tx_data_i  = 32'hE0 + 32'(i);
            net_rx_valid_i  = (i < 2);
            net_rx_data_i   = 32'hF0 + 32'(i);
            cyc();
        end
        idle_inputs();
        rst = 1'b1;
        #1;
        check("midrst_credits", 32'(tx_credits_o), 32'd4);
        check("midrst_rx_valid", 32'(core_rx_valid_o), 32'd0);
        check("midrst_rx_data", core_rx_data_o, 32'd0);
        check("midrst_tx_valid", 32'(net_tx_valid_o), 32'd0);
        check("midrst_tx_ready", 32'(core_tx_ready_o), 32'd1);
        cyc(2);
        #2 rst = 1'b0;
        base = tx_seen;
        net_tx_credit_i = 1'b0;
        core_rx_ready_i = 1'b1;
        cyc(10);
        core_rx_ready_i = 1'b0;
        check("midrst_no_stale_tx", 32'(tx_seen - base), 32'd0);
        check("midrst_no_stale_rx", 32'(core_rx_valid_o), 32'd0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            core_tx_valid_i = ($urandom_range(0, 1) == 1);
            core_tx_data_i  = $urandom;
            net_tx_credit_i = ((cred_m < TXC) || (tx_q.size() > 0)) && ($urandom_range(0, 2) != 0);
            net_rx_valid_i  = ($urandom_range(0, 1) == 1);
            net_rx_data_i   = $urandom;
            core_rx_ready_i = ($urandom_range(0, 3) != 0);
            cyc();
        end
        // Drain everything still in flight
        core_tx_valid_i = 1'b0;
        net_rx_valid_i  = 1'b0;
        core_rx_ready_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            net_tx_credit_i = (cred_m < TXC) || (tx_q.size() > 0);
            cyc();
        end
        idle_inputs();
        cyc(2);
        check("drain_tx_scoreboard", 32'(exp_tx.size()), 32'd0);
        check("drain_rx_scoreboard", 32'(exp_rx.size()), 32'd0);
        check("drain_credits", 32'(tx_credits_o), 32'd4);
        check("drain_rx_valid", 32'(core_rx_valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
